multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Finite-state controller that sequences a shared-memory, multi-cycle RV32I subset datapath (R-type ALU, I-type ALU, LW, SW). It fetches each instruction through a single memory port with a req/ready handshake, decodes the opcode, and drives the per-state datapath strobes. It also drives the 3-bit immediate-format select consumed by the immediate sign extender. The block counts retired instructions and halts on any unsupported opcode.

## Interface
- WORD_LENGTH, 32, width of `instr` and `retired_count`
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- instr  input  WORD_LENGTH  instruction-register output; valid from the DECODE state onward
- mem_ready  input  1  memory accepted/completed the current request this cycle
- mem_req  output  1  memory request; held until `mem_ready`
- mem_we  output  1  1 = write (store), 0 = read
- mem_addr_sel  output  1  0 = PC, 1 = ALU result
- ir_write  output  1  load the instruction register
- pc_write  output  1  PC <= PC+4
- reg_write  output  1  register-file write enable
- wb_sel  output  1  0 = ALU result, 1 = memory data
- alu_src_imm  output  1  ALU operand B is the immediate
- imm_sel  output  3  immediate format: 100 = I-ALU, 010 = load, 001 = store, 000 = none
- halted  output  1  illegal opcode seen; sticky
- retired_count  output  WORD_LENGTH  number of instructions retired

## Operation
- States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Asynchronous reset:
  - Forces state RST, `retired_count` = 0, and the internal opcode register = 0.
  - Every output is 0 in RST.
  - The first clock edge with `rst_n` high moves RST to FETCH.
- FETCH:
  - Outputs: `mem_req`=1, `mem_we`=0, `mem_addr_sel`=0.
  - `ir_write` = `mem_ready` (combinational).
  - If `mem_ready`, go to DECODE; otherwise stay in FETCH.
- DECODE:
  - Latch `instr[6:0]` into the opcode register.
  - Supported opcodes: 0110011 (R), 0010011 (I), 0000011 (LW), 0100011 (SW). Go to EXEC.
  - Any other opcode: go to HALT.
  - `imm_sel` is already driven from `instr[6:0]` in this state.
- EXEC:
  - `alu_src_imm` = 1 for I, LW, and SW; 0 for R.
  - Next state: R or I go to WB; LW or SW go to MEM.
- MEM:
  - Outputs: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for SW and 0 for LW.
  - Stay in MEM until `mem_ready`.
  - When `mem_ready` is seen: LW goes to WB; SW asserts `pc_write` in that same cycle and goes to FETCH.
- WB:
  - Outputs: `reg_write`=1, `pc_write`=1, `wb_sel`=1 for LW and 0 otherwise. Go to FETCH.
- HALT:
  - `halted`=1; all other strobes are 0.
  - HALT is absorbing; only reset leaves it.
- `imm_sel`:
  - Decoded from the latched opcode in EXEC, MEM, and WB (from `instr` in DECODE).
  - 000 for R-type, and 000 in RST, FETCH, and HALT.
- `retired_count`:
  - Increments by 1 on every clock edge where `pc_write`=1.
  - Wraps modulo 2^WORD_LENGTH.
- All outputs are combinational from the state, the latched opcode, and `mem_ready`. `retired_count` and the state are registered.

## Timing
- Zero-wait memory (`mem_ready` high in the same cycle as `mem_req`):
  - R/I: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 5 cycles.
  - SW: 4 cycles (FETCH, DECODE, EXEC, MEM).
- Each wait cycle in FETCH or MEM adds exactly 1 cycle. `mem_req` stays high and `mem_addr_sel`/`mem_we` stay stable throughout.
- `ir_write` and `pc_write` are single-cycle pulses, never high for 2 consecutive cycles.
- `mem_ready` outside FETCH and MEM is ignored.
- Reset mid-transaction:
  - `mem_req` drops in the same cycle `rst_n` falls (asynchronous).
  - The counter clears.
  - No `pc_write` or `reg_write` occurs for the aborted instruction.
- `retired_count` shows the new value one cycle after the `pc_write` cycle.

## Test plan
- **Reset release:** `rst_n` 0→1 → one cycle with all outputs 0, then `mem_req`=1 in FETCH; `retired_count`=0.
- **Zero-wait instruction stream:** stream ADD (0110011), ADDI (0010011), LW, SW with `mem_ready` tied to 1 → 4/4/5/4 cycles per instruction; `imm_sel` = 000/100/010/001 in EXEC; `retired_count`=4 after the SW.
- **Memory wait states:** LW with `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEM → 10 cycles total; `mem_req` continuously high during both waits; `ir_write` pulses exactly once.
- **Store sequencing:** SW → `mem_we`=1 only in MEM; `pc_write` in the same cycle as `mem_ready`; `reg_write` never asserted.
- **Illegal opcode:** opcode 1110011 → HALT after DECODE; `halted`=1 for 20+ cycles; `retired_count` unchanged; `mem_req` 0.
- **Mid-operation reset and counter wrap:**
  - Pulse `rst_n` low mid-MEM of a LW → `mem_req` 0 immediately, no `reg_write`, restart from RST.
  - Preload the counter to 0xFFFFFFFF → one retirement makes it 0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Memory-port handshake between the multicycle controller and the shared
// instruction/data memory.
//   mem_req      : controller requests an access, held until mem_ready
//   mem_we       : 1 = store, 0 = read
//   mem_addr_sel : address source, 0 = PC, 1 = ALU result
//   mem_ready    : memory accepted/completed the request this cycle
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencer for a shared-memory multicycle RV32I subset datapath
// (R-type ALU, I-type ALU, LW, SW). Fetches over one memory port, decodes
// the opcode, drives per-state datapath strobes and the immediate-format
// select, counts retired instructions and halts on unsupported opcodes.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   instr         : instruction-register output, valid from DECODE onward
//   mem           : memory handshake (req/we/addr_sel out, ready in)
//   ir_write      : load the instruction register
//   pc_write      : PC <= PC + 4
//   reg_write     : register-file write enable
//   wb_sel        : write-back source, 0 = ALU, 1 = memory data
//   alu_src_imm   : ALU operand B is the immediate
//   imm_sel       : immediate format, 100 = I-ALU, 010 = load, 001 = store
//   halted        : unsupported opcode seen (sticky until reset)
//   retired_count : instructions retired, wraps modulo 2^WORD_LENGTH
module multicycle_controller #(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WORD_LENGTH-1:0] instr,
  multicycle_controller_if.master mem,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   reg_write,
  output logic                   wb_sel,
  output logic                   alu_src_imm,
  output logic [2:0]             imm_sel,
  output logic                   halted,
  output logic [WORD_LENGTH-1:0] retired_count
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [6:0] opcode_q;
  logic [6:0] cur_op;
  logic       is_r;
  logic       is_i;
  logic       is_lw;
  logic       is_sw;
  logic       instr_unused;

  // Only the opcode field is consumed here.
  assign instr_unused = ^instr[WORD_LENGTH-1:7];

  // DECODE looks at the live instruction; later states use the latched copy.
  assign cur_op = (state_q == S_DECODE) ? instr[6:0] : opcode_q;
  assign is_r   = (cur_op == OP_R);
  assign is_i   = (cur_op == OP_I);
  assign is_lw  = (cur_op == OP_LW);
  assign is_sw  = (cur_op == OP_SW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RST;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opcode_q <= instr[6:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (pc_write) begin
      retired_count <= retired_count + WORD_LENGTH'(1);
    end
  end

  always_comb begin
    state_d          = state_q;
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    reg_write        = 1'b0;
    wb_sel           = 1'b0;
    alu_src_imm      = 1'b0;
    imm_sel          = 3'b000;
    halted           = 1'b0;

    if (state_q == S_DECODE || state_q == S_EXEC ||
        state_q == S_MEM    || state_q == S_WB) begin
      imm_sel = {is_i, is_lw, is_sw};
    end

    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ir_write    = mem.mem_ready;
        if (mem.mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_r || is_i || is_lw || is_sw) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        alu_src_imm = !is_r;
        if (is_r || is_i) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_HALT;
        end
      end
      S_MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = is_sw;
        if (mem.mem_ready) begin
          // A store retires on the memory handshake; a load still writes back.
          pc_write = is_sw;
          state_d  = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        wb_sel    = is_lw;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each instruction is expanded into
// its expected per-cycle phase list (inputs to drive plus outputs required),
// and one compare process checks every cycle. A second instance with an 8-bit
// counter exercises counter wrap-around.
module tb_multicycle_controller;

  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_ILL} kind_t;

  // exp bit order: {req, we, addr_sel, ir_write, pc_write, reg_write,
  //                 wb_sel, alu_src_imm, imm_sel[2:0], halted}
  typedef struct {
    logic        rst_n;
    logic        ready;
    logic [31:0] instr;
    logic [11:0] exp;
    logic [31:0] cnt;
  } cyc_t;

  cyc_t        sched[$];
  int          lit_at[$];
  logic [31:0] lit_cnt[$];
  logic        lit_halt[$];
  logic [31:0] model_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;
  bit active   = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_drv;

  logic        ir_write, pc_write, reg_write, wb_sel, alu_src_imm, halted;
  logic [2:0]  imm_sel;
  logic [31:0] retired_count;
  logic        ir_write8, pc_write8, reg_write8, wb_sel8, alu_src_imm8, halted8;
  logic [2:0]  imm_sel8;
  logic [7:0]  retired_count8;

  multicycle_controller_if mif();
  multicycle_controller_if mif8();

  multicycle_controller #(.WORD_LENGTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr_drv), .mem(mif),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .imm_sel(imm_sel),
    .halted(halted), .retired_count(retired_count)
  );

  multicycle_controller #(.WORD_LENGTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .instr(instr_drv[7:0]), .mem(mif8),
    .ir_write(ir_write8), .pc_write(pc_write8), .reg_write(reg_write8),
    .wb_sel(wb_sel8), .alu_src_imm(alu_src_imm8), .imm_sel(imm_sel8),
    .halted(halted8), .retired_count(retired_count8)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] outs(input logic req, input logic we,
      input logic asel, input logic ir, input logic pc, input logic rw,
      input logic wbs, input logic alui, input logic [2:0] imm,
      input logic halt);
    return {req, we, asel, ir, pc, rw, wbs, alui, imm, halt};
  endfunction

  function automatic logic [31:0] word_of(input kind_t k);
    case (k)
      K_R:     return 32'h0020_81B3;  // add  x3, x1, x2
      K_I:     return 32'h0050_0093;  // addi x1, x0, 5
      K_LW:    return 32'h0000_A203;  // lw   x4, 0(x1)
      K_SW:    return 32'h0040_A223;  // sw   x4, 4(x1)
      default: return 32'h0000_0073;  // ecall (opcode 1110011, unsupported)
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input kind_t k);
    case (k)
      K_I:     return 3'b100;
      K_LW:    return 3'b010;
      K_SW:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input logic rn, input logic rdy, input logic [31:0] w,
                      input logic [11:0] e);
    cyc_t c;
    if (!rn) model_cnt = '0;
    c.rst_n = rn;
    c.ready = rdy;
    c.instr = w;
    c.exp   = e;
    c.cnt   = model_cnt;
    sched.push_back(c);
    if (e[7]) model_cnt = model_cnt + 32'd1;  // retirement shows next cycle
  endtask

  task automatic add_reset(input int n);
    repeat (n) push(1'b0, 1'b1, JUNK, 12'h000);
    push(1'b1, 1'b1, JUNK, 12'h000);  // RST cycle: ready ignored, all zero
  endtask

  // fw/mw: wait cycles in fetch/memory; idle: mem_ready value where ignored
  task automatic add_instr(input kind_t k, input int fw, input int mw,
                           input logic idle);
    logic [31:0] w;
    logic [2:0]  m;
    logic        st;
    w  = word_of(k);
    m  = imm_of(k);
    st = (k == K_SW);
    repeat (fw) push(1'b1, 1'b0, JUNK, outs(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
    push(1'b1, 1'b1, JUNK, outs(1, 0, 0, 1, 0, 0, 0, 0, 3'b000, 0));
    push(1'b1, idle, w, outs(0, 0, 0, 0, 0, 0, 0, 0, m, 0));
    if (k == K_ILL) return;
    push(1'b1, idle, w, outs(0, 0, 0, 0, 0, 0, 0, k != K_R, m, 0));
    if (k == K_R || k == K_I) begin
      push(1'b1, idle, w, outs(0, 0, 0, 0, 1, 1, 0, 0, m, 0));
    end else begin
      repeat (mw) push(1'b1, 1'b0, w, outs(1, st, 1, 0, 0, 0, 0, 0, m, 0));
      push(1'b1, 1'b1, w, outs(1, st, 1, 0, st, 0, 0, 0, m, 0));
      if (k == K_LW) push(1'b1, idle, w, outs(0, 0, 0, 0, 1, 1, 1, 0, m, 0));
    end
  endtask

  task automatic add_lit(input int idx, input logic [31:0] cnt, input logic h);
    lit_at.push_back(idx);
    lit_cnt.push_back(cnt);
    lit_halt.push_back(h);
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, cur, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      cyc_t e;
      e = sched[cur];
      check("outputs", {20'd0, mif.mem_req, mif.mem_we, mif.mem_addr_sel,
            ir_write, pc_write, reg_write, wb_sel, alu_src_imm, imm_sel,
            halted}, {20'd0, e.exp});
      check("retired_count", retired_count, e.cnt);
      check("outputs8", {20'd0, mif8.mem_req, mif8.mem_we, mif8.mem_addr_sel,
            ir_write8, pc_write8, reg_write8, wb_sel8, alu_src_imm8, imm_sel8,
            halted8}, {20'd0, e.exp});
      check("retired_count8", {24'd0, retired_count8}, {24'd0, e.cnt[7:0]});
      for (int j = 0; j < lit_at.size(); j++) begin
        if (lit_at[j] == cur) begin
          logic [31:0] lc;
          lc = lit_cnt[j];
          check("lit_count", retired_count, lc);
          check("lit_count8", {24'd0, retired_count8}, {24'd0, lc[7:0]});
          check("lit_halted", {31'd0, halted}, {31'd0, lit_halt[j]});
        end
      end
    end
  end

  initial begin
    int s0;
    rst_n          = 1'b0;
    instr_drv      = JUNK;
    mif.mem_ready  = 1'b0;
    mif8.mem_ready = 1'b0;
    model_cnt      = '0;

    add_reset(2);
    s0 = sched.size(); add_instr(K_R, 0, 0, 1'b1);
    check("len_add", sched.size() - s0, 4);
    s0 = sched.size(); add_instr(K_I, 0, 0, 1'b1);
    check("len_addi", sched.size() - s0, 4);
    s0 = sched.size(); add_instr(K_LW, 0, 0, 1'b1);
    check("len_lw", sched.size() - s0, 5);
    s0 = sched.size(); add_instr(K_SW, 0, 0, 1'b1);
    check("len_sw", sched.size() - s0, 4);
    add_lit(sched.size(), 32'd4, 1'b0);
    s0 = sched.size(); add_instr(K_LW, 3, 2, 1'b0);
    check("len_lw_waits", sched.size() - s0, 10);
    add_instr(K_SW, 1, 1, 1'b0);

    // LW aborted by reset while waiting in MEM
    push(1'b1, 1'b1, JUNK, outs(1, 0, 0, 1, 0, 0, 0, 0, 3'b000, 0));
    push(1'b1, 1'b1, word_of(K_LW), outs(0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0));
    push(1'b1, 1'b1, word_of(K_LW), outs(0, 0, 0, 0, 0, 0, 0, 1, 3'b010, 0));
    push(1'b1, 1'b0, word_of(K_LW), outs(1, 0, 1, 0, 0, 0, 0, 0, 3'b010, 0));
    add_reset(2);
    add_lit(sched.size(), 32'd0, 1'b0);
    add_instr(K_I, 0, 0, 1'b1);

    add_instr(K_ILL, 0, 0, 1'b1);
    for (int i = 0; i < 22; i++) begin
      push(1'b1, logic'(i % 2), word_of(K_ILL),
           outs(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1));
    end
    add_lit(sched.size() - 1, 32'd1, 1'b1);

    add_reset(1);
    for (int i = 0; i < 256; i++) add_instr(kind_t'(i % 4), 0, 0, 1'b1);
    repeat (2) push(1'b1, 1'b0, JUNK, outs(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
    add_lit(sched.size() - 1, 32'd256, 1'b0);

    for (int i = 0; i < sched.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n          = sched[i].rst_n;
      instr_drv      = sched[i].instr;
      mif.mem_ready  = sched[i].ready;
      mif8.mem_ready = sched[i].ready;
      cur            = i;
      active         = 1'b1;
    end
    @(posedge clk);
    active = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
